// File: rtl/led_blink_array.sv
// -----------------------------------------------------------------------------
// led_blink_array
//
// Multi-channel LED blinker. Each of NUM_LEDS channels holds a mode
// (off / solid / blink / burst) and a toggle period that can be rewritten at
// any time through a one-cycle register-style write port.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   cfg_we      write strobe, one cycle per write
//   cfg_ch      channel index for the write (out-of-range writes are ignored)
//   cfg_mode    00 off, 01 solid on, 10 blink, 11 burst
//   cfg_period  cycles per toggle, 0 is treated as 1
//   led         registered LED drive, one bit per channel
//   busy        channel's stored mode is blink or burst
//   burst_done  one-cycle pulse when a channel's burst completes
//
// Optional feature
//   LED_BLINK_PHASE_ALIGN_EN: when defined, every accepted write also
//   restarts the phase (counter, burst counter, led start value) of every
//   other channel so that all blinking channels stay phase-aligned.
// -----------------------------------------------------------------------------
module led_blink_array #(
    parameter int NUM_LEDS       = 4,
    parameter int CNT_W          = 28,
    parameter int DEFAULT_PERIOD = 50_000_000,
    parameter int BURST_LEN      = 3,
    parameter int CH_W           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CNT_W-1:0]    cfg_period,
    output logic [NUM_LEDS-1:0] led,
    output logic [NUM_LEDS-1:0] busy,
    output logic [NUM_LEDS-1:0] burst_done
);

    // Burst counter must hold values up to 2*BURST_LEN.
    localparam int BC_W = $clog2(2 * BURST_LEN + 1);
    // A toggle taken while the burst counter holds this value is the last one.
    localparam logic [BC_W-1:0]  BURST_LAST   = BC_W'(2 * BURST_LEN - 1);
    localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(DEFAULT_PERIOD);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_SOLID = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_BURST = 2'b11
    } mode_t;

    logic cfg_ok;
    logic phase_clr;

    assign cfg_ok = cfg_we && (int'(cfg_ch) < NUM_LEDS);

`ifdef LED_BLINK_PHASE_ALIGN_EN
    assign phase_clr = cfg_ok;
`else
    assign phase_clr = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            mode_t            mode_reg,   mode_next;
            logic [CNT_W-1:0] period_reg, period_next;
            logic [CNT_W-1:0] cnt_reg,    cnt_next;
            logic [BC_W-1:0]  bcnt_reg,   bcnt_next;
            logic             led_reg,    led_next;
            logic             done_reg,   done_next;
            logic [CNT_W-1:0] term_cnt;
            logic             wr_hit;

            assign wr_hit = cfg_ok && (int'(cfg_ch) == gi);

            // Terminal count is Pe-1 with Pe = max(period, 1).
            assign term_cnt = (period_reg == '0) ? '0 : period_reg - CNT_W'(1);

            always_comb begin
                mode_next   = mode_reg;
                period_next = period_reg;
                cnt_next    = cnt_reg;
                bcnt_next   = bcnt_reg;
                led_next    = led_reg;
                done_next   = 1'b0;

                if (wr_hit) begin
                    // A write always wins over a coinciding toggle or burst end.
                    mode_next   = mode_t'(cfg_mode);
                    period_next = cfg_period;
                    cnt_next    = '0;
                    bcnt_next   = '0;
                    led_next    = (cfg_mode != MODE_OFF);
                end else if (phase_clr) begin
                    // Another channel was written: restart this one's phase.
                    cnt_next  = '0;
                    bcnt_next = '0;
                    led_next  = (mode_reg != MODE_OFF);
                end else begin
                    case (mode_reg)
                        MODE_SOLID: begin
                            led_next = 1'b1;
                            cnt_next = '0;
                        end
                        MODE_BLINK: begin
                            if (cnt_reg == term_cnt) begin
                                cnt_next = '0;
                                led_next = ~led_reg;
                            end else begin
                                cnt_next = cnt_reg + CNT_W'(1);
                            end
                        end
                        MODE_BURST: begin
                            if (cnt_reg == term_cnt) begin
                                cnt_next = '0;
                                if (bcnt_reg == BURST_LAST) begin
                                    // Final toggle: park dark and report done.
                                    bcnt_next = '0;
                                    led_next  = 1'b0;
                                    mode_next = MODE_OFF;
                                    done_next = 1'b1;
                                end else begin
                                    bcnt_next = bcnt_reg + BC_W'(1);
                                    led_next  = ~led_reg;
                                end
                            end else begin
                                cnt_next = cnt_reg + CNT_W'(1);
                            end
                        end
                        default: begin
                            led_next = 1'b0;
                            cnt_next = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mode_reg   <= MODE_OFF;
                    period_reg <= RESET_PERIOD;
                    cnt_reg    <= '0;
                    bcnt_reg   <= '0;
                    led_reg    <= 1'b0;
                    done_reg   <= 1'b0;
                end else begin
                    mode_reg   <= mode_next;
                    period_reg <= period_next;
                    cnt_reg    <= cnt_next;
                    bcnt_reg   <= bcnt_next;
                    led_reg    <= led_next;
                    done_reg   <= done_next;
                end
            end

            assign led[gi]        = led_reg;
            assign busy[gi]       = (mode_reg == MODE_BLINK) || (mode_reg == MODE_BURST);
            assign burst_done[gi] = done_reg;
        end
    endgenerate

endmodule

// File: tb/tb_led_blink_array.sv
// -----------------------------------------------------------------------------
// tb_led_blink_array
//
// Directed bench for led_blink_array (4 channels, reset period 4, burst of 3).
// A small per-channel model tracks the cycles elapsed since each channel's
// phase start; every cycle the expected led/busy/burst_done vectors are pushed
// into a scoreboard before the clock edge and popped and compared after it.
// Respects LED_BLINK_PHASE_ALIGN_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_led_blink_array;

    localparam int N    = 4;
    localparam int BL   = 3;
    localparam int DP   = 4;
    localparam int CW   = 8;
    localparam int CHW  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]    cfg_mode;
    logic [CW-1:0] cfg_period;
    logic [N-1:0]  led;
    logic [N-1:0]  busy;
    logic [N-1:0]  burst_done;

    led_blink_array #(
        .NUM_LEDS      (N),
        .CNT_W         (CW),
        .DEFAULT_PERIOD(DP),
        .BURST_LEN     (BL),
        .CH_W          (CHW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .cfg_period(cfg_period),
        .led       (led),
        .busy      (busy),
        .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [N-1:0] led;
        logic [N-1:0] busy;
        logic [N-1:0] done;
    } exp_t;

    exp_t sb[$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Model: mode, effective period, cycles since phase start.
    int m_mode[N];
    int m_per[N];
    int m_k[N];

    task automatic chk(input string name, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
        chk_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", name, obs, exp_v);
    endtask

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, " led"},  led,        e.led);
        chk({e.tag, " busy"}, busy,       e.busy);
        chk({e.tag, " done"}, burst_done, e.done);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mode[i] = 0;
            m_per[i]  = DP;
            m_k[i]    = 0;
        end
    endtask

    task automatic do_write(input int ch, input int mode, input int per);
        logic [31:0] chv;
        logic [31:0] modev;
        logic [31:0] perv;
        chv        = ch;
        modev      = mode;
        perv       = per;
        cfg_we     = 1'b1;
        cfg_ch     = chv[CHW-1:0];
        cfg_mode   = modev[1:0];
        cfg_period = perv[CW-1:0];
        $display("write ch=%0d mode=%0d period=%0d", ch, mode, per);
        if (ch < N) begin
`ifdef LED_BLINK_PHASE_ALIGN_EN
            for (int i = 0; i < N; i++) m_k[i] = 0;
`endif
            m_mode[ch] = mode;
            m_per[ch]  = (per == 0) ? 1 : per;
            m_k[ch]    = 0;
        end
    endtask

    // Predict this cycle's outputs, clock once, compare, advance the model.
    task automatic step(input string tag);
        exp_t e;
        int   pe;
        int   k;
        e.tag  = tag;
        e.led  = '0;
        e.busy = '0;
        e.done = '0;
        for (int i = 0; i < N; i++) begin
            pe = m_per[i];
            k  = m_k[i];
            case (m_mode[i])
                1: e.led[i] = 1'b1;
                2: begin
                    e.led[i]  = ((k / pe) % 2) == 0;
                    e.busy[i] = 1'b1;
                end
                3: begin
                    if (k < 2 * BL * pe) begin
                        e.led[i]  = ((k / pe) % 2) == 0;
                        e.busy[i] = 1'b1;
                    end else begin
                        e.done[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        compare_front();
        for (int i = 0; i < N; i++) begin
            if (m_mode[i] == 3 && m_k[i] >= 2 * BL * m_per[i]) m_mode[i] = 0;
            m_k[i]++;
        end
    endtask

    task automatic check_now(input string tag, input logic [N-1:0] el,
                             input logic [N-1:0] eb, input logic [N-1:0] ed);
        exp_t e;
        e.tag  = tag;
        e.led  = el;
        e.busy = eb;
        e.done = ed;
        sb.push_back(e);
        compare_front();
    endtask

    initial begin
        rst        = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_mode   = '0;
        cfg_period = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_now("in_reset", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b1;
        repeat (20) step("idle");

        // Channel 1 free-running blink, period 3.
        do_write(1, 2, 3);
        repeat (12) step("blink1");

        // Channel 2 burst, period 2: ends 12 cycles after the write.
        do_write(2, 3, 2);
        repeat (15) step("burst2");

        // Channel 0 period 0 toggles every cycle.
        do_write(0, 2, 0);
        repeat (7) step("fast0");
        // led[0] is 1 and at terminal count; the solid write must win.
        do_write(0, 1, 5);
        step("tc_solid0");
        repeat (3) step("solid0");

        // Out-of-range channel: nothing may change.
        do_write(4, 2, 3);
        repeat (5) step("oor");

        // Channel 3 burst interrupted by an asynchronous reset.
        do_write(3, 3, 4);
        repeat (6) step("burst3");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_now("async_rst", 4'b0000, 4'b0000, 4'b0000);
        repeat (2) step("rst_hold");
        rst = 1'b1;
        repeat (30) step("post_rst");

        // Two blinking channels; with phase alignment both restart together.
        do_write(1, 2, 5);
        repeat (3) step("align1");
        do_write(2, 2, 5);
        repeat (12) step("align2");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/led_blink_array.md
# led_blink_array

Parametrised multi-channel LED blinker and successor to the single-speed LED controller. Drives NUM_LEDS board LEDs, each with its own runtime-programmable toggle period and mode (off, solid, free-running blink, counted burst). Sits between the board-level wrapper and the LED pins; a register-style write port lets switches or a soft processor reprogram any channel on the fly.

## Interface
- NUM_LEDS, 4, number of LED channels (1–16)
- CNT_W, 28, width of the per-channel period and counter
- DEFAULT_PERIOD, 50_000_000, reset period of every channel (cycles per toggle)
- BURST_LEN, 3, on/off pairs emitted in burst mode (≥1)
- CH_W, $clog2(NUM_LEDS) (min 1), width of the channel index
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- cfg_we  input  1  write strobe, one cycle per write
- cfg_ch  input  CH_W  channel index for the write
- cfg_mode  input  2  00 off, 01 solid on, 10 blink, 11 burst
- cfg_period  input  CNT_W  cycles per toggle; 0 treated as 1
- led  output  NUM_LEDS  registered LED drive
- busy  output  NUM_LEDS  channel is in blink or burst mode
- burst_done  output  NUM_LEDS  one-cycle pulse when a burst completes

## Operation
- Per channel: stored mode (2 b), stored period (CNT_W), counter (CNT_W), burst toggle counter (wide enough for 2*BURST_LEN).
- Effective period Pe = max(period, 1).
- Write: on a clk edge with cfg_we=1 and cfg_ch<NUM_LEDS, the addressed channel loads cfg_mode/cfg_period, clears its counter and burst counter, and starts with led=1 for blink/burst, led=1 for solid, led=0 for off. cfg_ch≥NUM_LEDS: write ignored, no state changes.
- Off: led=0, counter held at 0. Solid: led=1, counter held at 0.
- Blink: counter increments each cycle; at counter==Pe-1, led toggles and counter returns to 0. Runs indefinitely.
- Burst: same as blink; each toggle increments the burst counter. On the toggle that makes it equal 2*BURST_LEN, led goes 0, the mode becomes off, and burst_done pulses for exactly one cycle.
- busy[i]=1 when the stored mode is blink or burst; it is combinational from the stored mode.
- Channels are fully independent except as modified by Configuration.
- Arithmetic is unsigned; the counter never exceeds Pe-1, so it never wraps.

## Timing
- Reset (rst=0, asynchronous): led=0, busy=0, burst_done=0, all modes off, all periods=DEFAULT_PERIOD, all counters 0. Release is synchronous to the next clk edge.
- Write latency: the new led value appears on the edge that samples cfg_we (visible the following cycle).
- In blink, led holds each level for exactly Pe cycles, giving a full cycle of 2*Pe clocks. Pe=1 toggles every cycle.
- Burst: the first edge of led is at the write; led falls to 0 finally 2*BURST_LEN*Pe cycles after the write; burst_done is asserted in that same cycle.
- Write coinciding with the channel's terminal count or final burst toggle: the write wins. There is no toggle and no burst_done.
- Back-to-back writes to the same channel: the last one wins each cycle; each write restarts the phase.
- A write to channel j does not disturb channel k≠j unless the Configuration macro is enabled.
- Reset asserted mid-burst: burst_done is not pulsed; all state is as at reset.

## Configuration
- LED_BLINK_PHASE_ALIGN_EN: when defined, any accepted write also clears the counter and burst counter of every channel and reloads led to its mode's start value (1 for solid/blink/burst, 0 for off). This keeps all blinking channels phase-aligned.
- When undefined: writes affect only the addressed channel, as described in Operation.

## Test plan
- Reset, then NUM_LEDS=4 with DEFAULT_PERIOD overridden to 4 -> led=0000, busy=0000; no change for 20 cycles after release.
- Write ch1 blink period 3 -> led[1]=1 for 3 cycles, 0 for 3 cycles, repeating; busy=0010; other LEDs stay 0.
- Write ch2 burst period 2, BURST_LEN=3 -> 6 toggles, led[2]=0 after 12 cycles, burst_done=0100 for exactly one cycle, busy[2] falls with it.
- Write ch0 period 0 blink -> led[0] toggles every cycle; then write ch0 mode 01 on ch0's terminal-count cycle -> led[0]=1 with no toggle.
- Write cfg_ch=4 (out of range) with blink -> no output or busy change.
- Pulse rst low mid-burst on ch3 -> led=0000 immediately (asynchronously), no burst_done. With LED_BLINK_PHASE_ALIGN_EN defined, blinking ch1 (period 5) while writing ch2 -> both restart at 1 on the same edge.
